piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
Parallel-in/serial-out transmitter with a parallel load handshake and a programmable bit period. A producer hands over one WIDTH-bit word per frame. The block shifts the word out on sdo, one bit every CLK_DIV clocks, then pulses done. It is the transmit-side counterpart of the team's SIPO register: with CLK_DIV=1 and LSB_FIRST=1, sdo feeds SIPO.d directly and the word reassembles in SIPO.q.

Parameters:
WIDTH, 8, word length in bits; legal range WIDTH >= 2
CLK_DIV, 4, clk cycles each bit is held on sdo; legal range CLK_DIV >= 1
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first

Ports:
clk  input  1  system clock; all state changes on posedge
reset_p  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word to transmit
load_valid  input  1  producer has a word on din
load_ready  output  1  block can accept a word (IDLE only)
sdo  output  1  serial data out
bit_strobe  output  1  one-cycle pulse on the first cycle of every bit
busy  output  1  high while a frame is shifting (SHIFT state)
done  output  1  one-cycle pulse after the last bit completes

Behaviour:
- Reset (async, reset_p=1): state=IDLE, shift reg=0, bit_cnt=0, div_cnt=0.
- Reset outputs: sdo=0, bit_strobe=0, busy=0, done=0, load_ready=1.
- All outputs are registered or decoded from registered state only; there is no combinational path from din or load_valid to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, sdo=0.
  - Accept occurs on a posedge where load_valid && load_ready. That edge is E0.
  - At E0: latch din into the shift reg, set bit_cnt=0 and div_cnt=0, go to SHIFT.
  - din is sampled only at E0; later changes to din have no effect on the frame.
- SHIFT:
  - busy=1, load_ready=0; load_valid is ignored.
  - Cycle index c counts clocks after E0, starting at c=0.
  - Bit k (k = 0..WIDTH-1) drives sdo for c = k*CLK_DIV .. (k+1)*CLK_DIV-1.
  - Bit order: LSB_FIRST=1 sends din[0] first; LSB_FIRST=0 sends din[WIDTH-1] first.
  - bit_strobe=1 at c = k*CLK_DIV for each k.
  - div_cnt counts 0..CLK_DIV-1 and wraps. On the wrap, shift one position and increment bit_cnt.
  - When the wrap coincides with bit_cnt == WIDTH-1, go to DONE instead of shifting.
  - CLK_DIV=1: a new bit every clock, and bit_strobe stays high for all WIDTH cycles.
- DONE:
  - Lasts exactly one cycle, at c = WIDTH*CLK_DIV.
  - done=1, busy=0, sdo=0, load_ready=0.
  - Next state is IDLE; load_ready returns to 1 at c = WIDTH*CLK_DIV+1.
- Frame length: WIDTH*CLK_DIV cycles of data plus 1 DONE cycle. Minimum accept-to-accept spacing is WIDTH*CLK_DIV+2 cycles.
- load_valid held high continuously: the next word is accepted on the first IDLE edge. No word is dropped or duplicated.
- Reset mid-frame: abort immediately. The in-flight word is discarded, no done pulse is generated, and all outputs take their reset values.
- Counter widths: bit_cnt is $clog2(WIDTH) bits and div_cnt is $clog2(CLK_DIV) bits (minimum 1). No counter overflows in any legal configuration.

Test Plan:
- Reset check: reset_p pulsed asynchronously between clock edges -> outputs go to reset values immediately (sdo=0, busy=0, done=0, load_ready=1) without waiting for a clk edge.
- WIDTH=8, CLK_DIV=4, LSB_FIRST=1, din=8'hA5, one-cycle load_valid:
  - sdo = 1,0,1,0,0,1,0,1, each held 4 clocks.
  - bit_strobe at c=0,4,...,28; done at c=32; load_ready=1 at c=33.
- Same stimulus with LSB_FIRST=0 -> sdo = 1,0,1,0,0,1,0,1 (8'hA5 is a palindrome). Repeat with din=8'h01 -> sdo = 0,0,0,0,0,0,0,1.
- Loopback, CLK_DIV=1, LSB_FIRST=1, din=8'h3C, sdo wired to SIPO.d with SIPO.rd_en=1 -> SIPO.q == 8'h3C during the done cycle.
- Back-to-back: load_valid held high with din=8'hF0, then 8'h0F -> second accept exactly 34 cycles after the first (CLK_DIV=4). Each word is transmitted once; load_valid asserted during SHIFT is not accepted.
- reset_p asserted at c=13 of a CLK_DIV=4 frame -> sdo=0, busy=0 immediately; no done pulse. A new word loaded after reset transmits correctly from bit 0.

Source files
------------

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter with load handshake and programmable bit period
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             sdo_q, sdo_d, bit_strobe_q, bit_strobe_d;
  logic             busy_q, busy_d, done_q, done_d, load_ready_q, load_ready_d;
  logic             accept, shifting, wrap, last;
  always_comb begin
    accept       = state_q == IDLE && load_valid;
    shifting     = state_q == SHIFT;
    wrap         = div_cnt_q == DW'(CLK_DIV - 1);
    last         = bit_cnt_q == BW'(WIDTH - 1);
    state_d      = state_q == IDLE ? (load_valid ? SHIFT : IDLE) :
                   shifting ? (wrap && last ? DONE : SHIFT) : IDLE;
    sr_d         = accept ? din :
                   (shifting && wrap && !last) ? (LSB_FIRST ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0}) :
                   sr_q;
    bit_cnt_d    = accept ? '0 : (shifting && wrap && !last) ? bit_cnt_q + 1'b1 : bit_cnt_q;
    div_cnt_d    = accept ? '0 : shifting ? (wrap ? '0 : div_cnt_q + 1'b1) : div_cnt_q;
    // Outputs are registered from next-state values so they line up with the state they describe
    sdo_d        = state_d == SHIFT && (LSB_FIRST ? sr_d[0] : sr_d[WIDTH-1]);
    bit_strobe_d = state_d == SHIFT && div_cnt_d == '0;
    busy_d       = state_d == SHIFT;
    done_d       = state_d == DONE;
    load_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      sdo_q        <= 1'b0;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      sdo_q        <= sdo_d;
      bit_strobe_q <= bit_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end
  assign sdo        = sdo_q;
  assign bit_strobe = bit_strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed checks of piso_shift_tx in three configurations
module tb_piso_shift_tx;
  logic       clk = 1'b0;
  logic       reset_p = 1'b0;
  logic [7:0] din [3];
  logic [2:0] lv = '0;
  logic [2:0] ready, sdo, strobe, busy, done;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(8), .CLK_DIV(4), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset_p(reset_p), .din(din[0]), .load_valid(lv[0]), .load_ready(ready[0]),
    .sdo(sdo[0]), .bit_strobe(strobe[0]), .busy(busy[0]), .done(done[0]));
  piso_shift_tx #(.WIDTH(8), .CLK_DIV(4), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset_p(reset_p), .din(din[1]), .load_valid(lv[1]), .load_ready(ready[1]),
    .sdo(sdo[1]), .bit_strobe(strobe[1]), .busy(busy[1]), .done(done[1]));
  piso_shift_tx #(.WIDTH(8), .CLK_DIV(1), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset_p(reset_p), .din(din[2]), .load_valid(lv[2]), .load_ready(ready[2]),
    .sdo(sdo[2]), .bit_strobe(strobe[2]), .busy(busy[2]), .done(done[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_all(input string tag);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("%s_u%0d_sdo", tag, u), int'(sdo[u]), 0);
      chk($sformatf("%s_u%0d_busy", tag, u), int'(busy[u]), 0);
      chk($sformatf("%s_u%0d_done", tag, u), int'(done[u]), 0);
      chk($sformatf("%s_u%0d_strobe", tag, u), int'(strobe[u]), 0);
      chk($sformatf("%s_u%0d_ready", tag, u), int'(ready[u]), 1);
    end
  endtask

  // One frame on unit u; expected bits come from the word, bit order and period supplied here
  task automatic frame(input int u, input logic [7:0] w, input int div, input bit lsb, input string tag);
    logic [7:0] rx = '0;
    int k;
    @(negedge clk);
    lv[u] = 1'b1;
    din[u] = w;
    @(negedge clk);
    lv[u] = 1'b0;
    din[u] = ~w;
    for (int c = 0; c < 8 * div; c++) begin
      k = c / div;
      chk($sformatf("%s_c%0d_sdo", tag, c), int'(sdo[u]), int'(lsb ? w[k] : w[7-k]));
      chk($sformatf("%s_c%0d_strobe", tag, c), int'(strobe[u]), int'(c % div == 0));
      chk($sformatf("%s_c%0d_busy", tag, c), int'(busy[u]), 1);
      chk($sformatf("%s_c%0d_ready", tag, c), int'(ready[u]), 0);
      chk($sformatf("%s_c%0d_done", tag, c), int'(done[u]), 0);
      if (c % div == 0) rx[k] = sdo[u];
      @(negedge clk);
    end
    chk({tag, "_done"}, int'(done[u]), 1);
    chk({tag, "_done_busy"}, int'(busy[u]), 0);
    chk({tag, "_done_sdo"}, int'(sdo[u]), 0);
    chk({tag, "_done_ready"}, int'(ready[u]), 0);
    if (div == 1) chk({tag, "_loopback_word"}, int'(rx), int'(lsb ? w : {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]}));
    @(negedge clk);
    chk({tag, "_after_ready"}, int'(ready[u]), 1);
    chk({tag, "_after_done"}, int'(done[u]), 0);
  endtask

  initial begin
    logic [7:0] rxw;
    logic [7:0] got [$];
    int bi, n_acc, t0, t1, n_done;
    for (int u = 0; u < 3; u++) din[u] = '0;
    #1 reset_p = 1'b1;
    #1 chk_idle_all("reset_async");
    @(negedge clk);
    @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
    chk_idle_all("reset_release");

    frame(0, 8'hA5, 4, 1'b1, "lsb_a5");
    frame(1, 8'hA5, 4, 1'b0, "msb_a5");
    frame(1, 8'h01, 4, 1'b0, "msb_01");
    frame(2, 8'h3C, 1, 1'b1, "div1_3c");

    // Back-to-back with load_valid held high
    @(negedge clk);
    lv[0] = 1'b1;
    din[0] = 8'hF0;
    n_acc = 0; n_done = 0; bi = 0; t0 = 0; t1 = 0; rxw = '0;
    for (int i = 0; i < 120; i++) begin
      if (strobe[0] && bi < 8) begin
        rxw[bi] = sdo[0];
        bi++;
      end
      if (done[0]) begin
        got.push_back(rxw);
        n_done++;
        bi = 0;
      end
      if (ready[0] && lv[0]) begin
        n_acc++;
        if (n_acc == 1) t0 = i;
        else t1 = i;
      end
      @(negedge clk);
      if (n_acc == 1) din[0] = 8'h0F;
      if (n_acc == 2) lv[0] = 1'b0;
    end
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_spacing", t1 - t0, 34);
    chk("b2b_dones", n_done, 2);
    chk("b2b_word0", got.size() > 0 ? int'(got[0]) : -1, 32'hF0);
    chk("b2b_word1", got.size() > 1 ? int'(got[1]) : -1, 32'h0F);

    // Reset mid-frame at c=13
    @(negedge clk);
    lv[0] = 1'b1;
    din[0] = 8'hFF;
    @(negedge clk);
    lv[0] = 1'b0;
    repeat (13) @(negedge clk);
    chk("midrst_pre_sdo", int'(sdo[0]), 1);
    chk("midrst_pre_busy", int'(busy[0]), 1);
    #1 reset_p = 1'b1;
    #1 chk_idle_all("midrst_async");
    #1 reset_p = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0]) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_ready", int'(ready[0]), 1);
    frame(0, 8'h96, 4, 1'b1, "post_rst_96");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
